// File: rtl/us_ptp_pkg.sv
// Shared definitions for the multi-channel ultrasonic PTP timer:
// register selects, CTRL bit positions and FSM state encoding.
package us_ptp_pkg;

   localparam logic [7:0] SEL_CTRL   = 8'h00;
   localparam logic [7:0] SEL_PLEN   = 8'h01;
   localparam logic [7:0] SEL_TOUT   = 8'h02;
   localparam logic [7:0] SEL_TURN   = 8'h03;
   localparam logic [7:0] SEL_STATUS = 8'h04;
   localparam logic [7:0] SEL_TRAVEL = 8'h05;
   localparam logic [7:0] SEL_PERIOD = 8'h06;
   localparam logic [7:0] SEL_SEQ    = 8'h07;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_MASTER = 1;
   localparam int CTRL_CONT   = 2;
   localparam int CTRL_START  = 3;

   localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TX,
      ST_LISTEN,
      ST_TURN,
      ST_GAP
   } state_e;

endpackage

// File: rtl/us_edge_sync.sv
// Multi-flop synchroniser for one asynchronous receive line, followed by
// a registered rising-edge detector (pulse SYNC_STAGES+1 cycles after the pin).
module us_edge_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              rise_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[STAGES-1];
         rise_q <= sync_q[STAGES-1] & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/us_ptp_multi_sync.sv
// Ultrasonic PTP master/slave timer: one piezo TX line, NUM_CH RX lines,
// Avalon-MM register interface with one stall cycle per read.
module us_ptp_multi_sync
   import us_ptp_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int HOLDOFF     = 1000
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [15:0]       avalon_slave_address,
   input  logic              avalon_slave_write,
   input  logic [31:0]       avalon_slave_writedata,
   input  logic              avalon_slave_read,
   output logic [31:0]       avalon_slave_readdata,
   output logic              avalon_slave_waitrequest,
   output logic              piezo_interface_out,
   input  logic [NUM_CH-1:0] piezo_interface_in
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] PLEN_RST = CNT_W'(20);
   localparam logic [CNT_W-1:0] GAP_LAST =
      CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

   logic [NUM_CH-1:0] rise;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_rx
      us_edge_sync #(
         .STAGES (SYNC_STAGES)
      ) u_sync (
         .clk_i  (clock),
         .rst_ni (reset_n),
         .d_i    (piezo_interface_in[g]),
         .rise_o (rise[g])
      );
   end

   state_e            state_q, state_d;
   logic [2:0]        ctrl_q, ctrl_d;
   logic              start_q, start_d;
   logic [CNT_W-1:0]  plen_q, plen_d;
   logic [CNT_W-1:0]  tout_q, tout_d;
   logic [CNT_W-1:0]  turn_q, turn_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  tmr_q, tmr_d;
   logic [CNT_W-1:0]  plat_q, plat_d;
   logic [CNT_W-1:0]  tlat_q, tlat_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [CNT_W-1:0]  travel_q [NUM_CH];
   logic [CNT_W-1:0]  travel_d [NUM_CH];
   logic [NUM_CH-1:0] valid_q, valid_d;
   logic              tflag_q, tflag_d;
   logic              prev_q, prev_d;
   logic              mst_q, mst_d;
   logic              wflag_q, wflag_d;
   logic [31:0]       seq_q, seq_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [7:0]        sel;
   logic [7:0]        idx;
   logic              en, master, cont;
   logic              busy, abort, arm, cnt_run;
   logic [CNT_W-1:0]  cnt_inc, plen_eff;
   logic [31:0]       rmux;

   assign sel      = avalon_slave_address[15:8];
   assign idx      = avalon_slave_address[7:0];
   assign en       = ctrl_q[CTRL_EN];
   assign master   = ctrl_q[CTRL_MASTER];
   assign cont     = ctrl_q[CTRL_CONT];
   assign busy     = (state_q != ST_IDLE);
   assign abort    = busy && (!en || (master != mst_q));
   assign cnt_run  = (state_q == ST_TX) || (state_q == ST_LISTEN) ||
                     (state_q == ST_TURN);
   assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
   assign plen_eff = (plen_q == '0) ? CNT_W'(1) : plen_q;

   always_comb begin
      ctrl_d  = ctrl_q;
      start_d = 1'b0;
      plen_d  = plen_q;
      tout_d  = tout_q;
      turn_d  = turn_q;
      if (avalon_slave_write) begin
         case (sel)
            SEL_CTRL: begin
               ctrl_d  = avalon_slave_writedata[2:0];
               start_d = avalon_slave_writedata[CTRL_START] &
                         avalon_slave_writedata[CTRL_EN];
            end
            SEL_PLEN: plen_d = avalon_slave_writedata[CNT_W-1:0];
            SEL_TOUT: tout_d = avalon_slave_writedata[CNT_W-1:0];
            SEL_TURN: turn_d = avalon_slave_writedata[CNT_W-1:0];
            default:  ;
         endcase
      end
   end

   always_comb begin
      rmux = DEADBEEF;
      case (sel)
         SEL_CTRL:   rmux = 32'(ctrl_q);
         SEL_PLEN:   rmux = 32'(plen_q);
         SEL_TOUT:   rmux = 32'(tout_q);
         SEL_TURN:   rmux = 32'(turn_q);
         SEL_STATUS: begin
            rmux             = '0;
            rmux[0]          = busy;
            rmux[1]          = tflag_q;
            rmux[8 +: NUM_CH] = valid_q;
         end
         SEL_TRAVEL: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (idx == 8'(i)) rmux = 32'(travel_q[i]);
            end
         end
         SEL_PERIOD: rmux = 32'(period_q);
         SEL_SEQ:    rmux = seq_q;
         default:    ;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      wflag_d = 1'b1;
      if (avalon_slave_read && wflag_q) begin
         rdata_d = rmux;
         wflag_d = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_run ? cnt_inc : cnt_q;
      tmr_d    = tmr_q;
      plat_d   = plat_q;
      tlat_d   = tlat_q;
      period_d = period_q;
      travel_d = travel_q;
      valid_d  = valid_q;
      tflag_d  = tflag_q;
      prev_d   = prev_q;
      mst_d    = mst_q;
      seq_d    = seq_q;
      arm      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (en && master && (start_q || cont)) begin
               arm = 1'b1;
            end else if (en && !master) begin
               state_d = ST_LISTEN;
               mst_d   = 1'b0;
               cnt_d   = '0;
               prev_d  = 1'b0;
            end
         end
         ST_TX: begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == plat_q - 1'b1) begin
               state_d = ST_LISTEN;
               tmr_d   = '0;
            end
         end
         ST_LISTEN: begin
            if (mst_q) begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (rise[i] && !valid_q[i]) begin
                     travel_d[i] = cnt_q;
                     valid_d[i]  = 1'b1;
                  end
               end
               if (&valid_d) begin
                  state_d = ST_GAP;
                  tmr_d   = '0;
                  seq_d   = seq_q + 1'b1;
               end else if (cnt_q >= tlat_q) begin
                  state_d = ST_GAP;
                  tmr_d   = '0;
                  tflag_d = 1'b1;
                  seq_d   = seq_q + 1'b1;
               end
            end else if (rise[0]) begin
               if (prev_q) begin
                  period_d   = cnt_q;
                  valid_d[0] = 1'b1;
                  seq_d      = seq_q + 1'b1;
               end
               // edge cycle counts as 0, so PERIOD is edge-to-edge distance
               prev_d  = 1'b1;
               cnt_d   = CNT_W'(1);
               tmr_d   = '0;
               state_d = ST_TURN;
            end
         end
         ST_TURN: begin
            tmr_d = tmr_q + 1'b1;
            if ((turn_q == '0) || (tmr_q == turn_q - 1'b1)) begin
               state_d = ST_TX;
               tmr_d   = '0;
               plat_d  = plen_eff;
            end
         end
         ST_GAP: begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == GAP_LAST) begin
               if (cont) arm = 1'b1;
               else      state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (arm) begin
         state_d = ST_TX;
         mst_d   = 1'b1;
         cnt_d   = '0;
         tmr_d   = '0;
         plat_d  = plen_eff;
         tlat_d  = tout_q;
         valid_d = '0;
         tflag_d = 1'b0;
      end
      if (abort) state_d = ST_IDLE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         ctrl_q   <= '0;
         start_q  <= 1'b0;
         plen_q   <= PLEN_RST;
         tout_q   <= CNT_MAX;
         turn_q   <= '0;
         cnt_q    <= '0;
         tmr_q    <= '0;
         plat_q   <= '0;
         tlat_q   <= '0;
         period_q <= '0;
         for (int i = 0; i < NUM_CH; i++) travel_q[i] <= '0;
         valid_q  <= '0;
         tflag_q  <= 1'b0;
         prev_q   <= 1'b0;
         mst_q    <= 1'b0;
         wflag_q  <= 1'b1;
         seq_q    <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         start_q  <= start_d;
         plen_q   <= plen_d;
         tout_q   <= tout_d;
         turn_q   <= turn_d;
         cnt_q    <= cnt_d;
         tmr_q    <= tmr_d;
         plat_q   <= plat_d;
         tlat_q   <= tlat_d;
         period_q <= period_d;
         travel_q <= travel_d;
         valid_q  <= valid_d;
         tflag_q  <= tflag_d;
         prev_q   <= prev_d;
         mst_q    <= mst_d;
         wflag_q  <= wflag_d;
         seq_q    <= seq_d;
         rdata_q  <= rdata_d;
      end
   end

   assign avalon_slave_readdata    = rdata_q;
   assign avalon_slave_waitrequest = avalon_slave_read & wflag_q;
   assign piezo_interface_out      = (state_q == ST_TX);

endmodule

// File: tb/tb_us_ptp_multi_sync.sv
// Bench for us_ptp_multi_sync: bus reads and slave turnaround delays are
// queued as expectations when driven and checked when the DUT responds.
module tb_us_ptp_multi_sync;

   localparam int NUM_CH = 4;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic [15:0]       avalon_slave_address = '0;
   logic              avalon_slave_write = 1'b0;
   logic [31:0]       avalon_slave_writedata = '0;
   logic              avalon_slave_read = 1'b0;
   logic [31:0]       avalon_slave_readdata;
   logic              avalon_slave_waitrequest;
   logic              piezo_interface_out;
   logic [NUM_CH-1:0] piezo_interface_in = '0;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   always #5 clock = ~clock;

   us_ptp_multi_sync #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (32),
      .SYNC_STAGES (2),
      .HOLDOFF     (200)
   ) dut (
      .clock                    (clock),
      .reset_n                  (reset_n),
      .avalon_slave_address     (avalon_slave_address),
      .avalon_slave_write       (avalon_slave_write),
      .avalon_slave_writedata   (avalon_slave_writedata),
      .avalon_slave_read        (avalon_slave_read),
      .avalon_slave_readdata    (avalon_slave_readdata),
      .avalon_slave_waitrequest (avalon_slave_waitrequest),
      .piezo_interface_out      (piezo_interface_out),
      .piezo_interface_in       (piezo_interface_in)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
      @(negedge clock);
      avalon_slave_address   = a;
      avalon_slave_writedata = d;
      avalon_slave_write     = 1'b1;
      @(negedge clock);
      avalon_slave_write     = 1'b0;
   endtask

   task automatic bus_rd(input logic [15:0] a, input logic [31:0] e,
                         input string tag);
      int          st;
      logic [31:0] ev;
      string       tv;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clock);
      avalon_slave_address = a;
      avalon_slave_read    = 1'b1;
      #1;
      st = 0;
      while (avalon_slave_waitrequest && st < 8) begin
         @(negedge clock);
         #1;
         st++;
      end
      ev = exp_q.pop_front();
      tv = tag_q.pop_front();
      chk({tv, "_stall"}, st, 1);
      chk(tv, avalon_slave_readdata, ev);
      avalon_slave_read = 1'b0;
   endtask

   task automatic wait_tx(input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clock);
         if (piezo_interface_out) ok = 1'b1;
      end
      chk(tag, ok, 1'b1);
   endtask

   initial begin
      int          hi;
      int          p;
      logic        prev_out;
      logic [31:0] ev;
      string       tv;

      @(negedge clock);
      chk("rst_out", piezo_interface_out, 1'b0);
      chk("rst_rdata", avalon_slave_readdata, 32'h0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;

      bus_rd(16'h0000, 32'h0, "rst_ctrl");
      bus_rd(16'h0100, 32'd20, "rst_plen");
      bus_rd(16'h0200, 32'hFFFF_FFFF, "rst_tout");
      bus_rd(16'h0300, 32'h0, "rst_turn");
      bus_rd(16'h0400, 32'h0, "rst_status");
      bus_rd(16'h0700, 32'h0, "rst_seq");
      bus_rd(16'h0507, 32'hDEAD_BEEF, "trv_idx7");
      bus_rd(16'h2000, 32'hDEAD_BEEF, "unmapped");
      bus_wr(16'h0700, 32'd123);
      bus_rd(16'h0700, 32'h0, "ro_seq");

      // master single-shot
      bus_wr(16'h0100, 32'd20);
      bus_wr(16'h0200, 32'd5000);
      bus_wr(16'h0000, 32'hB);
      wait_tx("m_txstart");
      hi = 1;
      for (int n = 1; n <= 800; n++) begin
         @(negedge clock);
         if (piezo_interface_out) hi++;
         for (int i = 0; i < NUM_CH; i++) begin
            if (n == 100 * (i + 1)) piezo_interface_in[i] = 1'b1;
         end
      end
      chk("m_plen", hi, 20);
      for (int i = 0; i < NUM_CH; i++) begin
         bus_rd(16'h0500 + 16'(i), 32'(100 * (i + 1) + 3), "m_travel");
      end
      bus_rd(16'h0400, 32'h0000_0F00, "m_status");
      bus_rd(16'h0700, 32'd1, "m_seq");
      bus_rd(16'h0000, 32'h3, "m_ctrl");
      piezo_interface_in = '0;
      repeat (10) @(negedge clock);

      // master timeout
      bus_wr(16'h0200, 32'd500);
      bus_wr(16'h0000, 32'hB);
      wait_tx("t_txstart");
      for (int n = 1; n <= 900; n++) begin
         @(negedge clock);
         if (n == 250) piezo_interface_in[1] = 1'b1;
      end
      bus_rd(16'h0501, 32'd253, "t_travel1");
      bus_rd(16'h0400, 32'h0000_0202, "t_status");
      bus_rd(16'h0700, 32'd2, "t_seq");
      piezo_interface_in = '0;
      repeat (10) @(negedge clock);

      // continuous mode
      bus_wr(16'h0000, 32'h7);
      for (int k = 0; k < 3; k++) begin
         wait_tx("c_txstart");
         for (int n = 1; n <= 100; n++) begin
            @(negedge clock);
            if (n == 50) piezo_interface_in = '1;
            if (n == 60) piezo_interface_in = '0;
         end
         bus_rd(16'h0502, 32'd53, "c_travel2");
         bus_rd(16'h0700, 32'(3 + k), "c_seq");
      end
      wait_tx("c_txstart4");
      repeat (30) @(negedge clock);
      bus_wr(16'h0000, 32'h6);
      bus_rd(16'h0400, 32'h0, "c_abort_status");
      chk("c_abort_out", piezo_interface_out, 1'b0);
      bus_rd(16'h0700, 32'd5, "c_abort_seq");

      // slave
      bus_wr(16'h0300, 32'd50);
      bus_wr(16'h0100, 32'd10);
      bus_wr(16'h0000, 32'h1);
      hi = 0;
      p = 0;
      prev_out = 1'b0;
      for (int n = 0; n <= 9200; n++) begin
         @(negedge clock);
         if (piezo_interface_out && !prev_out) begin
            if (exp_q.size() == 0) begin
               chk("s_unexpected_tx", 1'b1, 1'b0);
            end else begin
               ev = exp_q.pop_front();
               tv = tag_q.pop_front();
               chk(tv, 32'(n - p), ev);
            end
            hi = 0;
         end
         if (piezo_interface_out) hi++;
         if (!piezo_interface_out && prev_out) chk("s_plen", hi, 10);
         prev_out = piezo_interface_out;
         if ((n % 3000) == 0 && n < 9000) begin
            piezo_interface_in[0] = 1'b1;
            p = n;
            exp_q.push_back(32'd54);
            tag_q.push_back("s_turn");
         end
         if ((n % 3000) == 20) piezo_interface_in[0] = 1'b0;
         if (n == 1500) piezo_interface_in[1] = 1'b1;
         if (n == 1520) piezo_interface_in[1] = 1'b0;
      end
      chk("s_sb_empty", exp_q.size(), 0);
      exp_q.delete();
      tag_q.delete();
      bus_rd(16'h0600, 32'd3000, "s_period");
      bus_rd(16'h0700, 32'd7, "s_seq");
      bus_rd(16'h0400, 32'h0000_0101, "s_status");

      // async reset mid-TX
      bus_wr(16'h0000, 32'h0);
      bus_wr(16'h0100, 32'd20);
      bus_wr(16'h0000, 32'hB);
      wait_tx("r_txstart");
      repeat (3) @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("r_out", piezo_interface_out, 1'b0);
      chk("r_rdata", avalon_slave_readdata, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      bus_rd(16'h0000, 32'h0, "r_ctrl");
      bus_rd(16'h0100, 32'd20, "r_plen");
      bus_rd(16'h0200, 32'hFFFF_FFFF, "r_tout");
      bus_rd(16'h0700, 32'h0, "r_seq");
      bus_rd(16'h0600, 32'h0, "r_period");
      bus_rd(16'h0501, 32'h0, "r_travel1");
      bus_rd(16'h0400, 32'h0, "r_status");

      // start while disabled is ignored
      bus_wr(16'h0000, 32'h8);
      repeat (30) @(negedge clock);
      chk("d_out", piezo_interface_out, 1'b0);
      bus_rd(16'h0400, 32'h0, "d_status");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/us_ptp_multi_sync.md
Name: us_ptp_multi_sync

Overview:
- Parametrised successor of the single-channel ultrasonic PTP master/slave timer.
- Drives one piezo transmit line and watches NUM_CH piezo receive lines.
- Master mode: fires a ping, then timestamps the first echo on every channel, with timeout and continuous/single-shot operation.
- Slave mode: answers channel-0 pings after a programmable turnaround and measures the ping period. Sits on the lightweight-AXI Avalon-MM bus beside the other HPS-facing peripherals.

Parameters:
- NUM_CH, 4: number of piezo receive channels (1..16).
- CNT_W, 32: width of the timestamp counter and of the TRAVEL/PERIOD registers.
- SYNC_STAGES, 2: flip-flop stages on each receive input before edge detection.
- HOLDOFF, 1000: idle cycles between a master LISTEN end and the next TX in continuous mode.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- avalon_slave_address  in  16  [15:8] register select, [7:0] channel index.
- avalon_slave_write  in  1  write strobe.
- avalon_slave_writedata  in  32  write data.
- avalon_slave_read  in  1  read strobe.
- avalon_slave_readdata  out  32  read data.
- avalon_slave_waitrequest  out  1  read stall.
- piezo_interface_out  out  1  transmit pulse, active high.
- piezo_interface_in  in  NUM_CH  receive lines, asynchronous.

Behaviour:
- Reset (reset_n low, async):
  - All registers clear: piezo_interface_out=0, readdata=0, waitrequest=1 (gated with read), state IDLE.
  - CTRL=0, PULSE_LEN=20, TIMEOUT=2^CNT_W-1, TURNAROUND=0.
  - All TRAVEL/PERIOD=0, valid and timeout flags 0, SEQ=0.
- Register map (address[15:8]):
  - 0x00 CTRL rw: bit0 enable, bit1 master(1)/slave(0), bit2 continuous, bit3 start. Start is write-only, reads 0, self-clears.
  - 0x01 PULSE_LEN rw.
  - 0x02 TIMEOUT rw.
  - 0x03 TURNAROUND rw.
  - 0x04 STATUS ro: bit0 busy, bit1 timeout, bits[8+NUM_CH-1:8] per-channel valid.
  - 0x05 TRAVEL[address[7:0]] ro. Channel index >= NUM_CH reads 0xDEADBEEF.
  - 0x06 PERIOD ro.
  - 0x07 SEQ ro: completed-cycle count, wraps at 2^32.
  - Any other select reads 0xDEADBEEF.
  - Values narrower than 32 bits are zero-extended.
- Read timing: waitrequest=read & wait_flag. Data is registered and valid on the cycle waitrequest drops, i.e. 1 stall cycle per read.
- Write timing: zero wait states, takes effect next cycle. Writes to read-only selects are ignored.
- Receive inputs: each bit passes through SYNC_STAGES flops, then a rising-edge detector. Edge pulse latency is SYNC_STAGES+1 cycles after the pin rises.
- Counter: cnt increments every cycle in TX/LISTEN/TURN and saturates at 2^CNT_W-1; it never wraps.
- Master FSM:
  - IDLE -> TX on start=1, or on entering enabled+master+continuous. PULSE_LEN and TIMEOUT are latched at this transition. cnt:=0, valid:=0, timeout:=0.
  - TX: out=1 for latched PULSE_LEN cycles (0 treated as 1) -> LISTEN. cnt keeps running from the first TX cycle.
  - LISTEN:
    - First edge on channel i with valid[i]=0 sets TRAVEL[i]:=cnt and valid[i]:=1. Later edges are ignored. Simultaneous edges on several channels all capture the same cnt.
    - When all valid bits are set -> GAP.
    - When cnt==TIMEOUT -> GAP with timeout:=1. A channel edge in the same cycle is still captured.
  - GAP: SEQ+=1 on entry, wait HOLDOFF cycles. Then TX if continuous is set, else IDLE.
- Slave FSM:
  - IDLE -> LISTEN when enabled and slave.
  - LISTEN on a channel-0 edge (other channels ignored):
    - If a previous edge exists: PERIOD:=cnt, valid[0]:=1, SEQ+=1.
    - cnt:=0, -> TURN.
  - TURN: wait TURNAROUND cycles (0 means TX next cycle) -> TX.
  - TX: out=1 for PULSE_LEN cycles -> LISTEN. Edges during TURN/TX are ignored.
- Clearing enable, or toggling the mode bit, in any state: next cycle state=IDLE and out=0. Captured registers are held, busy=0. A start write while disabled is ignored.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package us_ptp_pkg holds:
  - register select constants (CTRL..SEQ);
  - CTRL bit indices;
  - FSM state encoding (IDLE, TX, LISTEN, TURN, GAP);
  - DEADBEEF constant.
- One sub-module, us_edge_sync: a SYNC_STAGES synchroniser plus rising-edge detector, instantiated once per channel in a generate loop.

Test Plan:
- Master single-shot:
  - Setup: PULSE_LEN=20, TIMEOUT=5000; write CTRL=0b1011.
  - Stimulus: raise ch0..3 at cycles 100/200/300/400 after the first TX cycle.
  - Expect: TRAVEL = 103/203/303/403 (SYNC_STAGES=2), valid=0xF, timeout=0, SEQ=1, state back in IDLE, out high for exactly 20 cycles.
- Master timeout: TIMEOUT=500, only ch1 echoes at 250 -> TRAVEL[1]=253, valid=0x2, timeout=1, GAP entered at cnt=500.
- Continuous mode: CTRL=0b0111, echoes every ping -> SEQ increments once per ping. Clearing enable mid-LISTEN drops out, busy=0 next cycle, and SEQ is unchanged.
- Slave:
  - Setup: TURNAROUND=50, PULSE_LEN=10; ch0 pings every 3000 cycles.
  - Expect: out rises 3+50+1 cycles after each ping pin edge, PERIOD=3000 after the second ping, SEQ counts pings minus one.
- Bus:
  - Read of TRAVEL with index 7 (NUM_CH=4) -> 0xDEADBEEF.
  - Unmapped select 0x20 -> 0xDEADBEEF.
  - Every read stalls exactly 1 cycle.
  - Asserting reset_n low mid-TX forces out=0 immediately (asynchronously) and all registers to their reset values.
